// File: rtl/audio_sample_player.sv
// Clip player: fetches 8-bit offset-binary samples at a fixed tick rate
// and presents them as signed 16-bit samples over a valid/ready handshake.
module audio_sample_player #(
  parameter int NUM_SAMPLES = 23490,
  parameter int TICK_DIV    = 6250
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        play,
  input  logic        stop,
  input  logic        loop_en,
  output logic        rom_re,
  output logic [31:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam int AW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    READ,
    LATCH,
    PRESENT
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   rom_addr_q;
  logic [CW-1:0]   cnt_q;
  logic            pend_q;
  logic            rom_re_q;
  logic [15:0]     sample_q;
  logic            valid_q;
  logic            done_q;
  logic            ovr_q;

  logic busy_d;
  logic tick_d;
  logic last_d;

  assign busy_d = (state_q != IDLE);
  assign tick_d = busy_d && (cnt_q == CW'(TICK_DIV - 1));
  assign last_d = (addr_q == AW'(NUM_SAMPLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rom_addr_q <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      rom_re_q   <= 1'b0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      rom_re_q <= 1'b0;
      if (busy_d) cnt_q <= tick_d ? '0 : cnt_q + 1'b1;
      // A tick outside WAIT_TICK is parked; a second one is lost.
      if (tick_d && state_q != WAIT_TICK) begin
        if (pend_q) ovr_q <= 1'b1;
        pend_q <= 1'b1;
      end
      if (stop) begin
        state_q <= IDLE;
        addr_q  <= '0;
        cnt_q   <= '0;
        pend_q  <= 1'b0;
        valid_q <= 1'b0;
      end else if (play) begin
        state_q    <= READ;
        addr_q     <= '0;
        cnt_q      <= '0;
        pend_q     <= 1'b0;
        ovr_q      <= 1'b0;
        valid_q    <= 1'b0;
        rom_re_q   <= 1'b1;
        rom_addr_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: state_q <= IDLE;
          WAIT_TICK: begin
            if (tick_d || pend_q) begin
              state_q    <= READ;
              rom_re_q   <= 1'b1;
              rom_addr_q <= addr_q;
              pend_q     <= tick_d && pend_q;
            end
          end
          READ: state_q <= LATCH;
          LATCH: begin
            sample_q <= {rom_data ^ 8'h80, 8'h00};
            valid_q  <= 1'b1;
            state_q  <= PRESENT;
          end
          PRESENT: begin
            if (sample_ready) begin
              valid_q <= 1'b0;
              if (!last_d) begin
                addr_q  <= addr_q + 1'b1;
                state_q <= WAIT_TICK;
              end else if (loop_en) begin
                addr_q  <= '0;
                state_q <= WAIT_TICK;
              end else begin
                addr_q  <= '0;
                cnt_q   <= '0;
                pend_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rom_re       = rom_re_q;
  assign rom_addr     = 32'(rom_addr_q);
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_d;
  assign done         = done_q;
  assign overrun      = ovr_q;

endmodule

// File: doc/audio_sample_player.md
AUDIO_SAMPLE_PLAYER -- requirements
Module: audio_sample_player

Interface
REQ-001 SHALL have parameter NUM_SAMPLES, default 23490, number of 8-bit samples stored in the clip memory.
REQ-002 SHALL have parameter TICK_DIV, default 6250, clock cycles per output sample (50 MHz / 8 kHz).
REQ-003 SHALL have port clock  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port play  in  1  single-cycle pulse; starts or restarts playback at address 0.
REQ-006 SHALL have port stop  in  1  single-cycle pulse; aborts playback.
REQ-007 SHALL have port loop_en  in  1  level; wraps playback to address 0 after the last sample.
REQ-008 SHALL have port rom_re  out  1  read enable to the clip memory.
REQ-009 SHALL have port rom_addr  out  32  read address to the clip memory.
REQ-010 SHALL have port rom_data  in  8  memory read data, valid one cycle after the rom_re cycle; unsigned offset-binary.
REQ-011 SHALL have port sample_out  out  16  signed sample to the codec path.
REQ-012 SHALL have port sample_valid  out  1  sample_out holds a sample not yet accepted.
REQ-013 SHALL have port sample_ready  in  1  downstream accepts sample_out.
REQ-014 SHALL have port busy  out  1  playback in progress (state not IDLE).
REQ-015 SHALL have port done  out  1  single-cycle pulse when a non-looped clip finishes.
REQ-016 SHALL have port overrun  out  1  sticky; a sample tick was lost; cleared by play or reset.

Function
REQ-017 SHALL implement the FSM states IDLE, WAIT_TICK, READ, LATCH and PRESENT.
REQ-018 SHALL, in IDLE, on play go to READ next cycle with addr=0, tick counter=0 and overrun=0.
REQ-019 SHALL, in READ, drive rom_re=1 and rom_addr=addr for exactly one cycle, then go to LATCH.
REQ-020 SHALL drive rom_re=0 in every state except READ.
REQ-021 SHALL, in LATCH, register sample_out = {rom_data XOR 8'h80, 8'h00}, e.g. 0x80->0x0000, 0xFF->0x7F00, 0x00->0x8000.
REQ-022 SHALL, on leaving LATCH, go to PRESENT with sample_valid=1.
REQ-023 SHALL raise sample_valid exactly 3 cycles after the tick or play that started the fetch.
REQ-024 SHALL, in PRESENT, hold sample_out and sample_valid stable until sample_valid && sample_ready.
REQ-025 SHALL, on that transfer edge, drop sample_valid and advance addr.
REQ-026 SHALL, when addr < NUM_SAMPLES-1 on transfer, increment addr and go to WAIT_TICK.
REQ-027 SHALL, when addr = NUM_SAMPLES-1 on transfer and loop_en=1, set addr=0 and go to WAIT_TICK.
REQ-028 SHALL, when addr = NUM_SAMPLES-1 on transfer and loop_en=0, pulse done for one cycle and go to IDLE.
REQ-029 SHALL run the tick counter 0..TICK_DIV-1, wrapping, only while busy.
REQ-030 SHALL produce a tick when the counter equals TICK_DIV-1.
REQ-031 SHALL hold a tick that arrives outside WAIT_TICK in a 1-deep pending flag.
REQ-032 SHALL, in WAIT_TICK, go to READ on a tick or on a set pending flag, clearing the pending flag.
REQ-033 SHALL set overrun when a tick arrives while the pending flag is already set; the lost tick is dropped.
REQ-034 SHALL make play while busy restart as in REQ-018, discarding any presented sample (sample_valid=0 next cycle) and the pending flag.
REQ-035 SHALL make stop, in any state, go to IDLE next cycle with sample_valid=0, pending flag=0 and no done pulse.
REQ-036 SHALL give stop priority over play when both assert in the same cycle.
REQ-037 SHALL give play and stop priority over a same-cycle handshake; the handshake sample counts as accepted, with no addr advance and no done pulse.
REQ-038 SHALL keep rom_addr zero-extended, with rom_addr < NUM_SAMPLES at all times.

Reset
REQ-039 SHALL, while reset=1, asynchronously force: state=IDLE, addr=0, tick counter=0, pending flag=0, rom_re=0, rom_addr=0, sample_out=0, sample_valid=0, busy=0, done=0, overrun=0.
REQ-040 SHALL treat reset asserted mid-playback identically, with no done pulse.
REQ-041 SHALL stay in IDLE after reset release until the next play.

Verification (bench: NUM_SAMPLES=4, TICK_DIV=8, memory model with 1-cycle read latency, contents 00,80,FF,41)
REQ-042 SHALL verify: play pulse, sample_ready=1 -> rom_re at +1 with addr 0; sample_valid at +3 with sample_out=0x8000; next fetches 8 cycles apart giving 0x0000, 0x7F00, 0xC100; done pulses once; busy=0 afterwards.
REQ-043 SHALL verify: loop_en=1, full clip -> after 0xC100 the next rom_addr=0 and sample_out=0x8000; no done; busy stays 1.
REQ-044 SHALL verify: sample_ready=0 for 20 cycles during PRESENT -> sample_out stable, one tick pending, overrun=1; after ready=1 the next READ follows immediately.
REQ-045 SHALL verify: play and stop in the same cycle during playback -> IDLE, busy=0, sample_valid=0, no done.
REQ-046 SHALL verify: play while PRESENT holds 0x7F00 -> sample_valid drops next cycle; next fetch at addr 0; overrun cleared.
REQ-047 SHALL verify: reset asserted mid-LATCH, asynchronous to the clock edge -> all outputs 0 immediately; no activity until the next play.
